pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Hardware pulse generator for the APB GPIO/timer subsystem.
- Drives one output pin with a programmed pattern: idle lead-in, N active pulses, idle gaps between them.
- Counterpart to the software pulseIn measurement. Used on-chip and in benches as the pulse source for pulseIn/timer capture tests, so benches no longer hand-code delays.
- All timing is in clk cycles. Configuration is latched at start.

Parameters:
- CNT_W, 32, width of the lead/pulse/gap length counters.
- NUM_W, 16, width of the pulse-count field and completed-pulse counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- abort_i  in  1  stop the current train immediately.
- idle_level_i  in  1  pin level outside pulses; the active level is its inverse.
- lead_len_i  in  CNT_W  idle cycles before the first pulse.
- pulse_len_i  in  CNT_W  active cycles per pulse.
- gap_len_i  in  CNT_W  idle cycles between pulses.
- pulse_num_i  in  NUM_W  number of pulses.
- pulse_o  out  1  generated waveform (registered).
- busy_o  out  1  a train is in progress.
- done_o  out  1  one-cycle strobe on normal completion.
- pulses_done_o  out  NUM_W  pulses completed in the current/last train.

Behaviour:
- Reset (rst=1 at a clk edge), outputs after that edge:
  - pulse_o = idle_level_i as sampled that cycle.
  - busy_o = 0, done_o = 0, pulses_done_o = 0.
  - State = IDLE.
- Reset dominates abort and start. Reset mid-train behaves exactly like reset from IDLE.
- States: IDLE, LEAD, PULSE, GAP. One down-counter (CNT_W) and one pulse counter (NUM_W).
- IDLE:
  - pulse_o tracks idle_level_i, registered with 1-cycle lag.
  - Start is accepted only if start_i=1, abort_i=0 and pulse_num_i != 0. Otherwise start_i is ignored and nothing changes.
- On accept at edge k:
  - All config inputs are latched; later changes are ignored until the next start.
  - busy_o=1 and pulses_done_o=0 from edge k.
  - If lead_len > 0: go to LEAD with count = lead_len. Otherwise go directly to PULSE.
- LEAD:
  - pulse_o = idle level.
  - Counter decrements each cycle. On the cycle count reaches 1, go to PULSE.
  - Result: the first active cycle is registered at edge k+L (L = lead_len), or k+1 when L = 0.
- PULSE:
  - pulse_o = active level for exactly max(pulse_len,1) cycles. pulse_len = 0 is treated as 1.
  - At the pulse's final cycle, pulses_done_o increments.
  - If more pulses remain: go to GAP with count = max(gap_len,1).
  - After the last pulse: go to IDLE. On that edge, pulse_o returns to idle level, busy_o=0, and done_o=1 for exactly one cycle.
- GAP:
  - pulse_o = idle level for max(gap_len,1) cycles, then go to PULSE.
  - gap_len = 0 is treated as 1, so consecutive pulses are always separated by at least one idle cycle.
- Arithmetic:
  - Counters are unsigned and never wrap. Max lengths are 2^CNT_W-1 cycles.
  - pulses_done_o saturates at pulse_num, which fits NUM_W by construction.
- Abort (abort_i=1 in LEAD/PULSE/GAP):
  - Next edge: state IDLE, pulse_o = idle level, busy_o = 0, done_o stays 0.
  - pulses_done_o holds the count of fully completed pulses; a truncated pulse is not counted.
  - Abort in IDLE has no effect.
- Simultaneous events:
  - start_i while busy is ignored; there is no queuing.
  - abort_i and start_i in the same IDLE cycle: abort wins and the start is dropped.
  - abort_i on the last pulse's final cycle: abort wins, done_o stays 0, and pulses_done_o does not count that pulse.
- New train in the cycle after done_o: allowed. start_i=1 in the done_o cycle is accepted, since state is IDLE.

Test Plan:
- 25 MHz clk, idle=0, lead=1250, pulse=12500, gap=25000, num=2 (the pulseIn stimulus pattern):
  - pulse_o high on [k+1250, k+13750) and [k+38750, k+51250).
  - done_o at edge k+51250, busy_o low from the same edge.
  - pulses_done_o = 2.
- idle=1, lead=0, pulse=0, gap=0, num=3:
  - pulse_o low at k+1, k+3 and k+5, high otherwise.
  - done_o at k+6.
- num=0 with start_i=1: busy_o stays 0, done_o never asserts, pulse_o unchanged.
- Abort:
  - num=4, pulse=10, gap=10; abort_i in the 5th cycle of pulse 2.
  - Next edge: pulse_o=idle, busy_o=0, no done_o, pulses_done_o=1.
- Start while busy and config change mid-train:
  - Change pulse_len_i and assert start_i during GAP.
  - Waveform keeps the latched values; exactly one done_o.
  - A start in the done_o cycle launches a new train.
- Reset mid-PULSE:
  - Next edge: pulse_o=idle, busy_o=0, pulses_done_o=0, no done_o.
  - A subsequent start behaves normally.

Source files
------------

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle for pulse_train_gen: train configuration, start/abort
// requests and the generated waveform with its status.
interface pulse_train_gen_if #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic             idle_level_i;
  logic [CNT_W-1:0] lead_len_i;
  logic [CNT_W-1:0] pulse_len_i;
  logic [CNT_W-1:0] gap_len_i;
  logic [NUM_W-1:0] pulse_num_i;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic [NUM_W-1:0] pulses_done_o;

  modport master (
    output start_i, abort_i, idle_level_i, lead_len_i, pulse_len_i,
           gap_len_i, pulse_num_i,
    input  pulse_o, busy_o, done_o, pulses_done_o
  );

  modport slave (
    input  start_i, abort_i, idle_level_i, lead_len_i, pulse_len_i,
           gap_len_i, pulse_num_i,
    output pulse_o, busy_o, done_o, pulses_done_o
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: idle lead-in, N active pulses separated by
// idle gaps, all lengths in clk cycles and latched when the train starts.
module pulse_train_gen #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_train_gen_if.slave     bus,
  output logic [1:0]           state_dbg
);

  // Handshake: start_i is a request that is taken on any edge where the FSM
  // is IDLE (busy_o low), abort_i low and pulse_num_i non-zero; busy_o high
  // means not ready, and requests seen then are dropped, never queued.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_nx;
  logic [CNT_W-1:0] gap_len_q, gap_len_nx;
  logic [NUM_W-1:0] num_q, num_nx;
  logic [NUM_W-1:0] done_cnt, done_cnt_nx, done_cnt_inc;
  logic             idle_q, idle_nx;
  logic             pulse_q, pulse_nx;
  logic             busy_q;
  logic             done_q, done_nx;
  logic             accept;
  logic             last_cycle;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pulse_len_nx = pulse_len_q;
    gap_len_nx   = gap_len_q;
    num_nx       = num_q;
    idle_nx      = idle_q;
    done_cnt_nx  = done_cnt;
    done_nx      = 1'b0;
    pulse_nx     = idle_q;
    accept       = bus.start_i && !bus.abort_i && (bus.pulse_num_i != '0);
    last_cycle   = (cnt == CNT_W'(1));
    done_cnt_inc = done_cnt + NUM_W'(1);

    case (state)
      IDLE: begin
        if (accept) begin
          // A zero lead still spends one cycle here, so the first active
          // level is registered one edge after the start is taken.
          state_nx     = LEAD;
          cnt_nx       = (bus.lead_len_i == '0) ? CNT_W'(1) : bus.lead_len_i;
          pulse_len_nx = (bus.pulse_len_i == '0) ? CNT_W'(1) : bus.pulse_len_i;
          gap_len_nx   = (bus.gap_len_i == '0) ? CNT_W'(1) : bus.gap_len_i;
          num_nx       = bus.pulse_num_i;
          idle_nx      = bus.idle_level_i;
          done_cnt_nx  = '0;
        end
      end
      LEAD, GAP: begin
        if (bus.abort_i) begin
          state_nx = IDLE;
        end else if (last_cycle) begin
          state_nx = PULSE;
          cnt_nx   = pulse_len_q;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      PULSE: begin
        if (bus.abort_i) begin
          state_nx = IDLE;
        end else if (last_cycle) begin
          done_cnt_nx = done_cnt_inc;
          if (done_cnt_inc == num_q) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = GAP;
            cnt_nx   = gap_len_q;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // The pin is registered from the next state; in IDLE it follows the input.
    if (state_nx == PULSE) begin
      pulse_nx = ~idle_q;
    end else if (state == IDLE) begin
      pulse_nx = bus.idle_level_i;
    end else begin
      pulse_nx = idle_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse_len_q <= '0;
      gap_len_q   <= '0;
      num_q       <= '0;
      idle_q      <= 1'b0;
      done_cnt    <= '0;
      pulse_q     <= bus.idle_level_i;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pulse_len_q <= pulse_len_nx;
      gap_len_q   <= gap_len_nx;
      num_q       <= num_nx;
      idle_q      <= idle_nx;
      done_cnt    <= done_cnt_nx;
      pulse_q     <= pulse_nx;
      busy_q      <= (state_nx != IDLE);
      done_q      <= done_nx;
    end
  end

  assign bus.pulse_o       = pulse_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.pulses_done_o = done_cnt;
  assign state_dbg         = state;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: hand-computed waveforms checked at key
// edges and through an expected-value queue.
`timescale 1ns/1ps
module tb_pulse_train_gen;
  localparam int CNT_W = 32;
  localparam int NUM_W = 16;
  localparam int OBS_W = 3;  // {pulse_o, busy_o, done_o}

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] trace[$];

  pulse_train_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [OBS_W-1:0] obs();
    return {bus.pulse_o, bus.busy_o, bus.done_o};
  endfunction

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic idle, input logic [CNT_W-1:0] lead,
                         input logic [CNT_W-1:0] plen, input logic [CNT_W-1:0] gap,
                         input logic [NUM_W-1:0] num);
    bus.idle_level_i = idle;
    bus.lead_len_i   = lead;
    bus.pulse_len_i  = plen;
    bus.gap_len_i    = gap;
    bus.pulse_num_i  = num;
  endtask

  // Starts a train (accept edge is trace[0]) and records n further edges.
  task automatic start_trace(input int n);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    trace.delete();
    trace.push_back(obs());
    repeat (n) begin
      tick();
      trace.push_back(obs());
    end
  endtask

  // scoreboard
  task automatic score_trace(input string tag);
    check_vec({tag, "_len"}, trace.size(), exp_q.size());
    for (int i = 0; i < trace.size(); i++) begin
      if (exp_q.size() > 0) check_vec($sformatf("%s[%0d]", tag, i), trace[i], exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  initial begin
    int highs;
    int dn;

    rst         = 1'b1;
    bus.abort_i = 1'b0;
    bus.start_i = 1'b1;
    set_cfg(1'b1, 0, 0, 0, 1);
    tick();
    tick();
    check_vec("rst_pulse", bus.pulse_o, 1'b1);
    check_vec("rst_busy", bus.busy_o, 1'b0);
    check_vec("rst_done", bus.done_o, 1'b0);
    check_vec("rst_cnt", bus.pulses_done_o, 0);
    check_vec("rst_state", state_dbg, 0);
    bus.start_i = 1'b0;
    rst = 1'b0;

    // idle tracking with one-cycle lag
    bus.idle_level_i = 1'b0;
    check_vec("idle_lag_hold", bus.pulse_o, 1'b1);
    tick();
    check_vec("idle_track", bus.pulse_o, 1'b0);

    // num=0 start, abort alone, abort+start together: all ignored
    set_cfg(1'b0, 5, 5, 5, 0);
    bus.start_i = 1'b1;
    repeat (3) tick();
    check_vec("num0_busy", bus.busy_o, 1'b0);
    check_vec("num0_done", bus.done_o, 1'b0);
    check_vec("num0_pulse", bus.pulse_o, 1'b0);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b1;
    tick();
    check_vec("idle_abort_state", state_dbg, 0);
    bus.pulse_num_i = 2;
    bus.start_i = 1'b1;
    tick();
    check_vec("abort_start_busy", bus.busy_o, 1'b0);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    tick();

    // pulseIn stimulus pattern
    set_cfg(1'b0, 1250, 12500, 25000, 2);
    start_trace(51251);
    check_vec("t1_busy_k", trace[0][1], 1'b1);
    check_vec("t1_p_1249", trace[1249][2], 1'b0);
    check_vec("t1_p_1250", trace[1250][2], 1'b1);
    check_vec("t1_p_13749", trace[13749][2], 1'b1);
    check_vec("t1_p_13750", trace[13750][2], 1'b0);
    check_vec("t1_p_38749", trace[38749][2], 1'b0);
    check_vec("t1_p_38750", trace[38750][2], 1'b1);
    check_vec("t1_51249", trace[51249], 3'b110);
    check_vec("t1_51250", trace[51250], 3'b001);
    check_vec("t1_51251", trace[51251], 3'b000);
    highs = 0;
    dn = 0;
    foreach (trace[i]) begin
      highs += int'(trace[i][2]);
      dn    += int'(trace[i][0]);
    end
    check_vec("t1_high_cycles", highs, 25000);
    check_vec("t1_done_count", dn, 1);
    check_vec("t1_pulses_done", bus.pulses_done_o, 2);

    // inverted idle, all lengths zero
    bus.idle_level_i = 1'b1;
    tick();
    set_cfg(1'b1, 0, 0, 0, 3);
    exp_q = '{3'b110, 3'b010, 3'b110, 3'b010, 3'b110, 3'b010, 3'b101, 3'b100};
    start_trace(7);
    score_trace("t2");
    check_vec("t2_pulses_done", bus.pulses_done_o, 3);

    // abort in the 5th cycle of pulse 2
    bus.idle_level_i = 1'b0;
    tick();
    set_cfg(1'b0, 0, 10, 10, 4);
    start_trace(25);
    check_vec("ab_pre_pulse", bus.pulse_o, 1'b1);
    check_vec("ab_pre_cnt", bus.pulses_done_o, 1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check_vec("ab_obs", obs(), 3'b000);
    check_vec("ab_cnt", bus.pulses_done_o, 1);
    tick();
    check_vec("ab_after_done", bus.done_o, 1'b0);
    check_vec("ab_after_state", state_dbg, 0);

    // abort on the final cycle of the last pulse
    set_cfg(1'b0, 0, 3, 0, 1);
    start_trace(3);
    check_vec("ablast_pre", bus.pulse_o, 1'b1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check_vec("ablast_obs", obs(), 3'b000);
    check_vec("ablast_cnt", bus.pulses_done_o, 0);
    tick();
    check_vec("ablast_no_done", bus.done_o, 1'b0);

    // start while busy plus config change mid-train, then restart on done
    set_cfg(1'b0, 2, 3, 4, 2);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check_vec("busy_start_k", bus.busy_o, 1'b1);
    highs = 0;
    dn = 0;
    for (int t = 1; t <= 12; t++) begin
      if (t == 6) begin
        bus.pulse_len_i = 20;
        bus.start_i = 1'b1;
      end
      if (t == 8) bus.start_i = 1'b0;
      tick();
      highs += int'(bus.pulse_o);
      dn    += int'(bus.done_o);
    end
    check_vec("bs_high_cycles", highs, 6);
    check_vec("bs_done_count", dn, 1);
    check_vec("bs_done_edge", obs(), 3'b001);
    bus.lead_len_i  = 0;
    bus.gap_len_i   = 1;
    bus.pulse_num_i = 1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check_vec("restart_obs", obs(), 3'b010);
    highs = 0;
    repeat (20) begin
      tick();
      highs += int'(bus.pulse_o);
    end
    check_vec("restart_high", highs, 20);
    tick();
    check_vec("restart_done", obs(), 3'b001);

    // reset in the middle of pulse 2
    set_cfg(1'b1, 0, 8, 2, 3);
    tick();
    start_trace(13);
    check_vec("rmid_pre_pulse", bus.pulse_o, 1'b0);
    check_vec("rmid_pre_cnt", bus.pulses_done_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_vec("rmid_obs", obs(), 3'b100);
    check_vec("rmid_cnt", bus.pulses_done_o, 0);
    check_vec("rmid_state", state_dbg, 0);
    tick();
    check_vec("rmid_no_done", bus.done_o, 1'b0);
    set_cfg(1'b0, 3, 2, 1, 2);
    tick();
    exp_q = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b010, 3'b110, 3'b110, 3'b001, 3'b000};
    start_trace(9);
    score_trace("t6");
    check_vec("t6_pulses_done", bus.pulses_done_o, 2);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
